// File: rtl/sdpram_stream_reader.sv
// Read-side controller for the simple-dual-port line buffer: turns (addr, len) commands into a
// backpressured valid/ready stream. Define SDPRAM_RD_OREG_EN when the RAM output register is enabled (L=3).
module sdpram_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

`ifdef SDPRAM_RD_OREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int DEPTH = 4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic [LAT-1:0]          r_pipe_v;
  logic [LAT-1:0]          r_pipe_last;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]        r_mem_last;
  logic [1:0]              r_wr_ptr;
  logic [1:0]              r_rd_ptr;
  logic [2:0]              r_cnt;

  logic                    w_pop;
  logic                    w_push;
  logic [2:0]              w_inflight;
  logic [3:0]              w_level;
  logic                    w_issue;
  logic                    w_issue_last;

  assign m_valid    = (r_cnt != 3'd0);
  assign m_data     = r_mem[r_rd_ptr];
  assign m_last     = m_valid & r_mem_last[r_rd_ptr];
  assign w_pop      = m_valid & m_ready;
  assign w_push     = r_pipe_v[LAT-1];
  assign w_inflight = 3'($countones(r_pipe_v));
  // Words already owed to the FIFO after this edge; keeping it below DEPTH makes overflow impossible.
  assign w_level    = 4'(r_cnt) + 4'(w_inflight) - 4'(w_pop);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_issue      = start && (start_len != '0);
        w_issue_last = (start_len == LEN_ONE);
      end
      S_ISSUE: begin
        w_issue      = (r_remaining != '0) && (w_level < 4'(DEPTH));
        w_issue_last = (r_remaining == LEN_ONE);
      end
      default: ;
    endcase
  end

  // In-flight pipe: a valid/last tag per outstanding read, aligned with the RAM latency.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_pipe_v    <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_v    <= {r_pipe_v[LAT-2:0], w_issue};
      r_pipe_last <= {r_pipe_last[LAT-2:0], w_issue & w_issue_last};
    end
  end

  // Show-ahead FIFO; the head entry drives the stream directly.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      // NOTE: this small storage is reset only because its head drives m_data, which must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_mem_last <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]      <= ram_rd_data;
        r_mem_last[r_wr_ptr] <= r_pipe_last[LAT-1];
        r_wr_ptr             <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      ram_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (start_len != '0) begin
              ram_rd_addr <= start_addr;
              r_addr      <= start_addr + ADDR_ONE;
              r_remaining <= start_len - LEN_ONE;
              busy        <= 1'b1;
              r_state     <= (start_len == LEN_ONE) ? S_DRAIN : S_ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            ram_rd_addr <= r_addr;
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && m_last && (w_inflight == 3'd0)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Directed bench for sdpram_stream_reader with a behavioural 2048x8 RAM (RAM[i]=i[7:0]).
// Define SDPRAM_RD_OREG_EN for both bench and RTL to exercise the registered-output RAM (L=3).
module tb_sdpram_stream_reader;

`ifdef SDPRAM_RD_OREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] start_len;
  logic        busy, done, m_valid, m_last, m_ready;
  logic [10:0] ram_rd_addr;
  logic [7:0]  ram_rd_data, m_data;

  int checks = 0;
  int errors = 0;

  sdpram_stream_reader dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .start_addr(start_addr),
    .start_len(start_len), .busy(busy), .done(done), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 rd_clk = ~rd_clk;

  // RAM model: address sampled on the edge after it is driven, optional output register.
  logic [7:0] ram [2048];
  logic [7:0] ram_q, ram_q2;
  initial for (int i = 0; i < 2048; i++) ram[i] = i[7:0];
  always @(posedge rd_clk) ram_q <= ram[ram_rd_addr];
`ifdef SDPRAM_RD_OREG_EN
  always @(posedge rd_clk) ram_q2 <= ram_q;
  assign ram_rd_data = ram_q2;
`else
  assign ram_rd_data = ram_q;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   32'(busy),        32'd0);
    chk({tag, "_done"},   32'(done),        32'd0);
    chk({tag, "_addr"},   32'(ram_rd_addr), 32'd0);
    chk({tag, "_valid"},  32'(m_valid),     32'd0);
    chk({tag, "_last"},   32'(m_last),      32'd0);
    chk({tag, "_data"},   32'(m_data),      32'd0);
  endtask

  // Drives a start strobe that is accepted at the following rising edge; returns #1 after it.
  task automatic issue_cmd(input logic [10:0] addr, input logic [11:0] len);
    @(negedge rd_clk);
    start = 1'b1; start_addr = addr; start_len = len;
    @(posedge rd_clk);
    #1 start = 1'b0; start_addr = 11'h5A5; start_len = 12'hABC;
  endtask

  // Consumes up to 'stop' beats of an n-beat command starting at 'base'. Data is checked on every
  // valid cycle, so a stall that changes m_data/m_last is caught. Completion checked when stop==n.
  task automatic run_stream(input string tag, input int n, input int stop, input logic [10:0] base,
                            input bit rand_ready, input bit gapless);
    int idx = 0;
    int cyc = 0;
    while (idx < stop && cyc < 300) begin
      @(negedge rd_clk);
      cyc++;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gapless) chk({tag, "_gapless"}, 32'(m_valid), 32'd1);
      if (m_valid) begin
        chk({tag, "_data"}, 32'(m_data), 32'(8'(base + 11'(idx))));
        chk({tag, "_last"}, 32'(m_last), 32'(idx == n - 1));
        if (m_ready) idx++;
      end
    end
    chk({tag, "_beats"}, 32'(idx), 32'(stop));
    if (stop == n) begin
      @(negedge rd_clk);
      chk({tag, "_done"},      32'(done),    32'd1);
      chk({tag, "_busy_off"},  32'(busy),    32'd0);
      chk({tag, "_no_extra"},  32'(m_valid), 32'd0);
      @(negedge rd_clk);
      chk({tag, "_done_pulse"}, 32'(done),   32'd0);
    end
  endtask

  initial begin
    logic [10:0] wrap_addrs [4];
    int c;
    wrap_addrs = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    rd_rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; m_ready = 1'b0;
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    chk_reset_outputs("reset");
    rd_rst = 1'b0;

    // Basic read with first-beat latency and back-to-back beats.
    issue_cmd(11'h010, 12'd8);
    @(negedge rd_clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_first_addr", 32'(ram_rd_addr), 32'h010);
    c = 0;
    while (!m_valid && c < 20) begin
      @(negedge rd_clk);
      c++;
    end
    chk("t1_latency", 32'(c), 32'(LAT));
    run_stream("t1", 8, 8, 11'h010, 1'b0, 1'b1);

    // Address wrap; sink stalled while the issued addresses are observed.
    m_ready = 1'b0;
    issue_cmd(11'h7FE, 12'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge rd_clk);
      else @(negedge rd_clk);
      chk("t2_rd_addr", 32'(ram_rd_addr), 32'(wrap_addrs[i]));
    end
    run_stream("t2", 4, 4, 11'h7FE, 1'b0, 1'b0);

    // Random backpressure.
    issue_cmd(11'h100, 12'd16);
    run_stream("t3", 16, 16, 11'h100, 1'b1, 1'b0);

    // Zero-length command.
    m_ready = 1'b1;
    issue_cmd(11'h300, 12'd0);
    @(negedge rd_clk);
    chk("t4_zero_done", 32'(done), 32'd1);
    chk("t4_zero_busy", 32'(busy), 32'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge rd_clk);
      chk("t4_zero_novalid", 32'(m_valid), 32'd0);
    end

    // Start while busy must be ignored.
    issue_cmd(11'h200, 12'd4);
    @(negedge rd_clk);
    start = 1'b1; start_addr = 11'h300; start_len = 12'd5;
    @(posedge rd_clk);
    #1 start = 1'b0;
    run_stream("t4_busy", 4, 4, 11'h200, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge rd_clk);
      chk("t4_ignored", 32'({busy, m_valid}), 32'd0);
    end

    // Reset in the middle of a 20-beat command, then a fresh 3-beat command.
    issue_cmd(11'h400, 12'd20);
    run_stream("t5_pre", 20, 5, 11'h400, 1'b0, 1'b0);
    @(negedge rd_clk);
    rd_rst = 1'b1;
    #1 chk_reset_outputs("t5_rst");
    repeat (2) @(negedge rd_clk);
    rd_rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge rd_clk);
      chk("t5_discarded", 32'({done, m_valid}), 32'd0);
    end
    issue_cmd(11'h020, 12'd3);
    run_stream("t5_post", 3, 3, 11'h020, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
